// File: rtl/logic_74hc191_driver_if.sv
// Control/status bus between the emulator sequencer and the 74HC191 stimulus driver.
interface logic_74hc191_driver_if #(
  parameter int unsigned CW = 8
);
  logic          START;
  logic          ABORT;
  logic          DIR;
  logic          PRESET_EN;
  logic [3:0]    PRESET;
  logic [CW-1:0] COUNT;
  logic          STOP_ON_TC;
  logic          BUSY;
  logic          DONE;
  logic          TC_SEEN;
  logic [CW-1:0] PULSES;

  modport master (
    output START, ABORT, DIR, PRESET_EN, PRESET, COUNT, STOP_ON_TC,
    input  BUSY, DONE, TC_SEEN, PULSES
  );

  modport slave (
    input  START, ABORT, DIR, PRESET_EN, PRESET, COUNT, STOP_ON_TC,
    output BUSY, DONE, TC_SEEN, PULSES
  );
endinterface

// File: rtl/logic_74hc191_driver.sv
// Drives clock, direction, load and enable pins of an emulated 74HC191 with an
// optional parallel load followed by a burst of registered count pulses.
module logic_74hc191_driver #(
  parameter int unsigned HALF = 2,
  parameter int unsigned CW   = 8
) (
  input  logic                         CLK,
  input  logic                         nRST,
  logic_74hc191_driver_if.slave        ctrl,
  input  logic                         TC_IN,
  output logic                         CP_OUT,
  output logic                         nUD_OUT,
  output logic                         nPL_OUT,
  output logic                         nCE_OUT,
  output logic [3:0]                   D_OUT
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETUP,
    LOW,
    HIGH,
    FINISH
  } state_t;

  localparam logic [7:0] HALF_LAST = 8'(HALF - 1);

  state_t        state;
  state_t        stateNext;
  logic [7:0]    timer;
  logic          halfDone;
  logic          startAcc;
  logic          tcStop;

  logic [CW-1:0] capCount;
  logic          capStopOnTc;
  logic [CW-1:0] pulses;
  logic          tcSeen;
  logic          busy;
  logic          done;

  assign halfDone     = (timer == HALF_LAST);
  assign ctrl.BUSY    = busy;
  assign ctrl.DONE    = done;
  assign ctrl.TC_SEEN = tcSeen;
  assign ctrl.PULSES  = pulses;

  // ABORT overrides every transition; in IDLE it also suppresses START.
  always_comb begin
    stateNext = state;
    startAcc  = 1'b0;
    tcStop    = 1'b0;
    if (ctrl.ABORT && (state != IDLE)) begin
      stateNext = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (ctrl.START && !ctrl.ABORT) begin
            startAcc  = 1'b1;
            stateNext = ctrl.PRESET_EN ? LOAD : SETUP;
          end
        end
        LOAD: begin
          if (halfDone) stateNext = SETUP;
        end
        SETUP: begin
          if (halfDone) stateNext = (capCount == '0) ? FINISH : LOW;
        end
        LOW: begin
          if (halfDone) stateNext = HIGH;
        end
        HIGH: begin
          if (halfDone) begin
            if (capStopOnTc && TC_IN) begin
              tcStop    = 1'b1;
              stateNext = FINISH;
            end else if (pulses == capCount) begin
              stateNext = FINISH;
            end else begin
              stateNext = LOW;
            end
          end
        end
        FINISH: stateNext = IDLE;
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= stateNext;
      if (stateNext != state) begin
        timer <= '0;
      end else if ((state != IDLE) && (state != FINISH)) begin
        timer <= timer + 8'd1;
      end
    end
  end

  // Pin outputs are decoded from the next state and registered, so each pin
  // changes exactly on the state-entry edge and never glitches.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      CP_OUT      <= 1'b0;
      nUD_OUT     <= 1'b0;
      nPL_OUT     <= 1'b1;
      nCE_OUT     <= 1'b1;
      D_OUT       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      tcSeen      <= 1'b0;
      pulses      <= '0;
      capCount    <= '0;
      capStopOnTc <= 1'b0;
    end else begin
      CP_OUT  <= (stateNext == HIGH);
      nPL_OUT <= (stateNext != LOAD);
      nCE_OUT <= !((stateNext == SETUP) || (stateNext == LOW) || (stateNext == HIGH));
      busy    <= (stateNext != IDLE);
      done    <= (stateNext == FINISH);
      if (startAcc) begin
        capCount    <= ctrl.COUNT;
        capStopOnTc <= ctrl.STOP_ON_TC;
        nUD_OUT     <= ctrl.DIR;
        pulses      <= '0;
        tcSeen      <= 1'b0;
        if (ctrl.PRESET_EN) D_OUT <= ctrl.PRESET;
      end else begin
        if ((stateNext == HIGH) && (state != HIGH)) pulses <= pulses + CW'(1);
        if (tcStop) tcSeen <= 1'b1;
      end
    end
  end

endmodule

// File: doc/logic_74hc191_driver.md
# logic_74hc191_driver

Stimulus generator for the emulated 4-bit up/down counter chain: drives the counter's clock, direction, parallel-load and enable pins, and monitors its terminal-count output. Given a preset value, direction and pulse count, it optionally parallel-loads the counter, then emits a burst of clean, glitch-free count pulses. The burst can stop early on terminal count. It sits between the emulator's control/sequencer logic and one counter instance (or the first stage of a cascaded chain).

## Interface
Parameters:
- HALF, default 2: system-clock cycles per half-period of CP_OUT and per nPL_OUT low phase; legal range 1..255.
- CW, default 8: width of the pulse-count request.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- nRST  input  1  asynchronous, active-low reset.
- START  input  1  one-cycle request; sampled only in IDLE.
- ABORT  input  1  terminates any burst; highest priority after reset.
- DIR  input  1  count direction captured at START; 0 = up, 1 = down (same encoding as nUD).
- PRESET_EN  input  1  captured at START; 1 = perform a parallel load before counting.
- PRESET  input  4  load value captured at START.
- COUNT  input  CW  number of CP_OUT rising edges to emit, captured at START.
- STOP_ON_TC  input  1  captured at START; 1 = end the burst when TC_IN is seen high.
- TC_IN  input  1  terminal count from the counter.
- CP_OUT  output  1  counter clock; counting edge is rising.
- nUD_OUT  output  1  counter direction.
- nPL_OUT  output  1  counter parallel load, active low.
- nCE_OUT  output  1  counter enable, active low.
- D_OUT  output  4  counter parallel data.
- BUSY  output  1  burst in progress.
- DONE  output  1  one-cycle pulse at normal or TC-stop completion.
- TC_SEEN  output  1  sticky; set when a burst ended on TC; cleared at the next START.
- PULSES  output  CW  rising edges emitted in the current or last burst.

## Operation
- States: IDLE, LOAD, SETUP, LOW, HIGH, FINISH. Half-period timer counts HALF cycles per state (except IDLE and FINISH).
- IDLE: if START=1, capture DIR, PRESET_EN, PRESET, COUNT and STOP_ON_TC. Clear PULSES and TC_SEEN. Go to LOAD if PRESET_EN=1, else SETUP.
- LOAD: nPL_OUT=0 and D_OUT=PRESET for HALF cycles. CP_OUT stays 0. Then go to SETUP.
- SETUP: nCE_OUT=0 and nUD_OUT=DIR for HALF cycles. Then go to FINISH if COUNT=0, else LOW.
- LOW: CP_OUT=0 for HALF cycles, then go to HIGH.
- HIGH: CP_OUT=1 for HALF cycles. PULSES increments on the cycle HIGH is entered. On the last HIGH cycle, sample TC_IN:
  - If STOP_ON_TC=1 and TC_IN=1: set TC_SEEN and go to FINISH.
  - Else if PULSES=COUNT: go to FINISH.
  - Else: go to LOW.
- FINISH: CP_OUT=0, nCE_OUT=1, DONE=1 for one cycle, then go to IDLE.
- nUD_OUT changes only in IDLE→LOAD/SETUP transitions and is held stable through the entire burst. CP_OUT is a registered output, so it cannot glitch.
- START while not IDLE is ignored. Captured values are immune to input changes mid-burst.
- ABORT in any non-IDLE state: the next cycle enters IDLE with CP_OUT=0, nPL_OUT=1, nCE_OUT=1. DONE is not pulsed, and PULSES holds its value. ABORT and START together in IDLE: ABORT wins, and no burst starts.
- PULSES is CW bits wide and cannot wrap, since COUNT ≤ 2^CW−1.

## Timing
- Reset values: CP_OUT=0, nUD_OUT=0, nPL_OUT=1, nCE_OUT=1, D_OUT=0, BUSY=0, DONE=0, TC_SEEN=0, PULSES=0; state IDLE.
- Reset asserted mid-burst: all outputs return to reset values immediately (asynchronously), with no DONE.
- Cycle numbering: START is sampled on edge 0. The first non-IDLE state's outputs are visible in cycle 1, and BUSY=1 from cycle 1.
- BUSY=0 in the cycle after DONE. DONE and BUSY are both 1 in the FINISH cycle.
- Timing for N pulses (N>0), without preset: SETUP occupies cycles 1..HALF. Rising edge k (k=1..N) of CP_OUT occurs at cycle 1+HALF+(2k−1)·HALF. FINISH occurs at cycle 1+HALF+2N·HALF.
- With preset: every value above is shifted by HALF cycles.
- TC response: TC_IN must be valid by the last cycle of HIGH. A TC stop ends the burst at a falling CP_OUT edge, never mid-pulse.

## Test plan
- HALF=2, COUNT=3, PRESET_EN=0, DIR=0, START at edge 0 -> CP_OUT rises at cycles 5, 9 and 13. DONE pulses in cycle 15. PULSES=3, nUD_OUT=0 throughout, nPL_OUT stays 1.
- HALF=2, PRESET_EN=1, PRESET=4'hA, COUNT=2, DIR=1 -> nPL_OUT=0 with D_OUT=4'hA in cycles 1–2. Rises occur at cycles 7 and 11. An attached counter ends at 4'h8, and DONE pulses in cycle 13.
- HALF=1, PRESET=4'hD, DIR=0, COUNT=10, STOP_ON_TC=1, with the counter attached -> TC_IN goes high after the 2nd rise. The burst stops with PULSES=2 and TC_SEEN=1, and DONE pulses once.
- COUNT=0, PRESET_EN=1 -> load phase only, no CP_OUT edges, DONE at cycle 2·HALF+1, PULSES=0.
- ABORT asserted while in HIGH mid-burst -> next cycle: IDLE, CP_OUT=0, nCE_OUT=1, no DONE. A second START during the burst is ignored. START with ABORT together in IDLE -> stays IDLE.
- nRST pulsed low during LOAD -> nPL_OUT=1, CP_OUT=0, BUSY=0 immediately. A new START afterwards runs a normal burst.
